// File: rtl/single_port_ram_clr.sv
// Single-port RAM with selectable async/sync read and a sequential
// zero-fill engine that runs after reset or on a clear request.
module single_port_ram_clr #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cptr;
    logic [ADDR_WIDTH-1:0] w_cptr_nxt;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic                  w_wen;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // The clear engine borrows the single write port from the user.
    always_comb begin
        w_state_nxt = r_state;
        w_cptr_nxt  = r_cptr;
        w_wen       = 1'b0;
        w_waddr     = addr;
        w_wdata     = din;
        unique case (r_state)
            S_IDLE: begin
                w_wen = we;
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_cptr_nxt  = '0;
                end
            end
            S_CLEAR: begin
                w_wen      = 1'b1;
                w_waddr    = r_cptr;
                w_wdata    = '0;
                w_cptr_nxt = r_cptr + 1'b1;
                if (r_cptr == LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_cptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cptr  <= w_cptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wen) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign busy = (r_state == S_CLEAR);

    generate
        if (READ_MODE == 1) begin : g_sync
            logic [DATA_WIDTH-1:0] r_dout;

            // Read-first: the array read sees the pre-edge contents.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (r_state == S_CLEAR) begin
                    r_dout <= '0;
                end else begin
                    r_dout <= r_mem[addr];
                end
            end

            assign dout = busy ? '0 : r_dout;
        end else begin : g_async
            assign dout = busy ? '0 : r_mem[addr];
        end
    endgenerate

endmodule

// File: tb/tb_single_port_ram_clr.sv
// Directed bench: async, sync-read and no-clear-on-reset instances
// of single_port_ram_clr exercised from one sequence of tasks.
module tb_single_port_ram_clr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_we = 1'b0, a_clr = 1'b0, a_busy;
    logic [7:0] a_addr = '0, a_din = '0, a_dout;
    logic       s_we = 1'b0, s_clr = 1'b0, s_busy;
    logic [7:0] s_addr = '0, s_din = '0, s_dout;
    logic       c_we = 1'b0, c_clr = 1'b0, c_busy;
    logic [7:0] c_addr = '0;
    logic [0:0] c_din = '0, c_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    single_port_ram_clr #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8),
        .READ_MODE(0), .CLEAR_ON_RESET(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .we(a_we), .addr(a_addr),
        .din(a_din), .clr(a_clr), .dout(a_dout), .busy(a_busy)
    );

    single_port_ram_clr #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8),
        .READ_MODE(1), .CLEAR_ON_RESET(1)
    ) u_s (
        .clk(clk), .rst_n(rst_n), .we(s_we), .addr(s_addr),
        .din(s_din), .clr(s_clr), .dout(s_dout), .busy(s_busy)
    );

    single_port_ram_clr #(
        .DATA_WIDTH(1), .ADDR_WIDTH(8),
        .READ_MODE(0), .CLEAR_ON_RESET(0)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .we(c_we), .addr(c_addr),
        .din(c_din), .clr(c_clr), .dout(c_dout), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] ad, input logic [7:0] d);
        a_we = 1'b1; a_addr = ad; a_din = d;
        tick();
        a_we = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_a: got %b want 1", a_busy);
        end
        checks++;
        if (c_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_c: got %b want 0", c_busy);
        end
        checks++;
        if (s_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout_s: got %h want 00", s_dout);
        end
        rst_n = 1'b1;
        n = 0;
        while (a_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d want 256", n);
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_s_end: got %b want 0", s_busy);
        end
        foreach (a_din[i]) begin end
        a_addr = 8'h00; #1;
        checks++;
        if (a_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_00: got %h want 00", a_dout);
        end
        a_addr = 8'h7F; #1;
        checks++;
        if (a_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_7f: got %h want 00", a_dout);
        end
        a_addr = 8'hFF; #1;
        checks++;
        if (a_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_ff: got %h want 00", a_dout);
        end
    endtask

    task automatic test_async();
        a_write(8'h00, 8'hA5);
        a_write(8'hFF, 8'h3C);
        a_addr = 8'h00; #1;
        checks++;
        if (a_dout !== 8'hA5) begin
            errors++;
            $display("FAIL async_rd_00: got %h want a5", a_dout);
        end
        a_addr = 8'hFF; #1;
        checks++;
        if (a_dout !== 8'h3C) begin
            errors++;
            $display("FAIL async_rd_ff: got %h want 3c", a_dout);
        end
        a_we = 1'b1; a_addr = 8'h00; a_din = 8'h5A; #1;
        checks++;
        if (a_dout !== 8'hA5) begin
            errors++;
            $display("FAIL async_pre_edge: got %h want a5", a_dout);
        end
        tick();
        checks++;
        if (a_dout !== 8'h5A) begin
            errors++;
            $display("FAIL async_post_edge: got %h want 5a", a_dout);
        end
        a_we = 1'b0;
    endtask

    task automatic test_sync();
        s_we = 1'b1; s_addr = 8'h10; s_din = 8'h77;
        tick();
        checks++;
        if (s_dout !== 8'h00) begin
            errors++;
            $display("FAIL sync_read_first: got %h want 00", s_dout);
        end
        s_we = 1'b0;
        tick();
        checks++;
        if (s_dout !== 8'h77) begin
            errors++;
            $display("FAIL sync_read_new: got %h want 77", s_dout);
        end
        s_addr = 8'h11;
        tick();
        checks++;
        if (s_dout !== 8'h00) begin
            errors++;
            $display("FAIL sync_read_11: got %h want 00", s_dout);
        end
    endtask

    task automatic test_clear();
        int n;
        int bad;
        for (int i = 0; i < 256; i++) begin
            a_write(8'(i), 8'(i) ^ 8'hFF);
        end
        a_addr = 8'h20; #1;
        checks++;
        if (a_dout !== 8'hDF) begin
            errors++;
            $display("FAIL fill_rd_20: got %h want df", a_dout);
        end
        a_we = 1'b1; a_addr = 8'h30; a_din = 8'h99; a_clr = 1'b1;
        tick();
        a_we = 1'b0; a_clr = 1'b0; a_addr = 8'h20;
        n = 0;
        while (a_busy === 1'b1 && n < 400) begin
            if (n == 5) begin
                a_we = 1'b1; a_din = 8'h11;
            end else begin
                a_we = 1'b0;
            end
            if (n == 6) begin
                checks++;
                if (a_dout !== 8'h00) begin
                    errors++;
                    $display("FAIL clear_dout_forced: got %h want 00", a_dout);
                end
            end
            tick();
            n++;
        end
        a_we = 1'b0;
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d want 256", n);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            a_addr = 8'(i); #1;
            if (a_dout !== 8'h00) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clear_all_zero: got %0d nonzero want 0", bad);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        repeat (100) tick();
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL midclr_busy_before: got %b want 1", a_busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (s_dout !== 8'h00) begin
            errors++;
            $display("FAIL midclr_sync_dout: got %h want 00", s_dout);
        end
        n = 0;
        while (a_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL midclr_busy_len: got %0d want 256", n);
        end
    endtask

    task automatic test_no_clear_reset();
        checks++;
        if (c_busy !== 1'b0) begin
            errors++;
            $display("FAIL cor0_busy: got %b want 0", c_busy);
        end
        c_we = 1'b1; c_addr = 8'hFF; c_din = 1'b1;
        tick();
        c_addr = 8'h00; c_din = 1'b0;
        tick();
        c_we = 1'b0;
        c_addr = 8'hFF; #1;
        checks++;
        if (c_dout !== 1'b1) begin
            errors++;
            $display("FAIL cor0_rd_ff: got %b want 1", c_dout);
        end
        c_addr = 8'h00; #1;
        checks++;
        if (c_dout !== 1'b0) begin
            errors++;
            $display("FAIL cor0_rd_00: got %b want 0", c_dout);
        end
    endtask

    initial begin
        test_reset();
        test_async();
        test_sync();
        test_clear();
        test_reset_mid_clear();
        test_no_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/single_port_ram_clr.md
Name: single_port_ram_clr

Overview:
Parametrised single-port RAM, generalised from the 256x1 asynchronous-read cell to configurable width, depth and read mode.
Adds a built-in sequential clear engine that zero-fills every word after reset or on request, and reports busy while clearing.
Used as general scratch/line storage in the display and memory projects.
Maps to distributed RAM when READ_MODE=0, and to block RAM when READ_MODE=1.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words
READ_MODE, 0, 0 = asynchronous read; 1 = synchronous registered read, read-first
CLEAR_ON_RESET, 1, 1 = enter clear sequence when leaving reset; 0 = go straight to IDLE, contents undefined

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
we  input  1  write enable
addr  input  ADDR_WIDTH  read/write address
din  input  DATA_WIDTH  write data
clr  input  1  single-cycle clear request, honoured only in IDLE
dout  output  DATA_WIDTH  read data
busy  output  1  high while clear sequence runs; user accesses ignored

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- State machine, states IDLE and CLEAR, plus internal clear pointer cptr (ADDR_WIDTH bits).
- Reset (rst_n=0 at a rising edge):
  - cptr <= 0.
  - state <= CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Registered dout (READ_MODE=1) <= 0.
  - Memory array is not reset directly.
  - busy is registered and reads 1 in the cycle after reset when CLEAR_ON_RESET=1, else 0.
- Reset asserted mid-clear: the sequence restarts at cptr=0.
- CLEAR state:
  - Each cycle writes mem[cptr] <= 0 and increments cptr.
  - When cptr = 2**ADDR_WIDTH-1 is written, cptr wraps to 0 and state <= IDLE.
  - Exactly 2**ADDR_WIDTH cycles with busy=1.
- IDLE state:
  - clr=1 -> CLEAR next cycle with cptr=0; busy=1 from that cycle.
  - clr and we both high in the same IDLE cycle: the write is performed, then the clear starts and erases it.
- During CLEAR:
  - we and clr are ignored; no user write reaches memory.
  - dout is forced to 0 in both read modes.
- Writes (IDLE only): we=1 writes din to mem[addr] on the rising edge.
- READ_MODE=0:
  - dout = mem[addr] combinationally; zero latency.
  - After a write edge, dout shows the new data for the same addr.
- READ_MODE=1:
  - dout <= mem[addr] each IDLE cycle; one-cycle latency.
  - Read-during-write to the same addr returns the old contents, read-first.
  - dout holds 0 through the first IDLE edge after clear, then tracks.
- Width rules:
  - addr is used unmodified; all 2**ADDR_WIDTH locations are addressable.
  - No wrap or saturation on user addresses.
  - cptr wraps naturally.
- No out-of-range conditions exist; depth is always a power of two.

Test Plan:
1. Reset, then release rst_n, with DATA_WIDTH=8, ADDR_WIDTH=8 (CLEAR_ON_RESET=1):
   -> busy=1 for exactly 256 cycles, then 0.
   -> Reads of addr 0x00, 0x7F and 0xFF then return 0x00.
2. Async mode, write 0xA5 to 0x00 and 0x3C to 0xFF:
   -> dout=0xA5 as soon as addr=0x00, with no clock edge needed.
   -> dout=0x3C at addr=0xFF.
   -> Re-write 0x00 with 0x5A: dout changes to 0x5A right after the edge.
3. Sync mode, we=1, addr=0x10, din=0x77, where old data is 0x00:
   -> dout=0x00 at the write edge (read-first).
   -> Next edge with we=0 -> dout=0x77.
4. Fill 0x00-0xFF with addr^0xFF, then pulse clr for one cycle:
   -> busy=1 for 256 cycles.
   -> A we=1, addr=0x20, din=0x11 issued during busy has no effect.
   -> Afterwards every address reads 0x00.
5. Reset mid-clear: assert rst_n=0 for one cycle at cptr=100:
   -> Clear restarts from 0; busy stays high for a further full 256 cycles after the release.
6. CLEAR_ON_RESET=0, DATA_WIDTH=1:
   -> busy=0 right after reset.
   -> Write 1 to 0xFF and 0 to 0x00; read back 1 and 0.
